// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream packet FIFO.
package axis_pkg;

  typedef enum logic {
    WRITE   = 1'b0,
    DISCARD = 1'b1
  } pkt_wr_state_t;

  // Distance from b to a for pointers that wrap modulo 2**width.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module sdp_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO; frames that cannot fit are dropped whole.
//
// state   | meaning
// WRITE   | storing beats of the current frame at wr_ptr
// DISCARD | swallowing the tail of a frame that overflowed
module axis_packet_fifo
  import axis_pkg::*;
#(
  parameter int AXIS_BYTES = 1,
  parameter int DEPTH      = 2048,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    sresetn,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic                    axis_i_tlast,
  input  logic [8*AXIS_BYTES-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [8*AXIS_BYTES-1:0] axis_o_tdata,
  output logic                    drop_pulse,
  output logic [ADDR_W:0]         frames_stored
);

  localparam int DW = 8 * AXIS_BYTES;
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(DEPTH);

  pkt_wr_state_t   wr_state;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] commit_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] used;
  logic            full;
  logic            in_acc;
  logic            ram_we;
  logic            commit;

  logic [DW:0]     ram_q;
  logic [DW:0]     skid_q;
  logic [DW:0]     head;
  logic            ram_vld;
  logic            skid_vld;
  logic            avail;
  logic            rd_en;
  logic            pop;
  logic            pop_skid;
  logic            pop_ram;
  logic            q_keep;
  logic            q_move;
  logic            last_pop;

  // Space is judged against the registered rd_ptr, so a same-cycle read frees nothing yet.
  assign used   = (ADDR_W+1)'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), ADDR_W + 1));
  assign full   = (used == PTR_FULL);
  assign in_acc = axis_i_tvalid && axis_i_tready;
  assign ram_we = in_acc && (wr_state == WRITE) && !full;
  assign commit = ram_we && axis_i_tlast;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      wr_state      <= WRITE;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      drop_pulse    <= 1'b0;
      axis_i_tready <= 1'b0;
    end else begin
      axis_i_tready <= 1'b1;
      drop_pulse    <= 1'b0;
      if (in_acc) begin
        case (wr_state)
          WRITE: begin
            if (!full) begin
              wr_ptr <= wr_ptr + PTR_ONE;
              if (axis_i_tlast) commit_ptr <= wr_ptr + PTR_ONE;
            end else begin
              // Rewind only the speculative pointer; committed frames and the reader are untouched.
              wr_ptr     <= commit_ptr;
              drop_pulse <= 1'b1;
              if (!axis_i_tlast) wr_state <= DISCARD;
            end
          end
          DISCARD: begin
            if (axis_i_tlast) wr_state <= WRITE;
          end
          default: wr_state <= WRITE;
        endcase
      end
    end
  end

  sdp_ram #(
    .WIDTH (DW + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata ({axis_i_tlast, axis_i_tdata}),
    .re    (rd_en),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  // Output head: skid holds the older beat, the RAM read register the next one.
  assign avail    = (rd_ptr != commit_ptr);
  assign pop      = axis_o_tvalid && axis_o_tready;
  assign pop_skid = skid_vld && axis_o_tready;
  assign pop_ram  = !skid_vld && ram_vld && axis_o_tready;
  assign q_keep   = ram_vld && !pop_ram;
  assign rd_en    = avail && !(q_keep && skid_vld && !pop_skid);
  assign q_move   = q_keep && (!skid_vld || pop_skid);
  assign last_pop = pop && axis_o_tlast;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      rd_ptr        <= '0;
      ram_vld       <= 1'b0;
      skid_vld      <= 1'b0;
      skid_q        <= '0;
      frames_stored <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      ram_vld <= rd_en || (q_keep && !q_move);
      if (q_move) begin
        skid_vld <= 1'b1;
        skid_q   <= ram_q;
      end else if (pop_skid) begin
        skid_vld <= 1'b0;
      end
      case ({commit, last_pop})
        2'b10:   frames_stored <= frames_stored + PTR_ONE;
        2'b01:   frames_stored <= frames_stored - PTR_ONE;
        default: frames_stored <= frames_stored;
      endcase
    end
  end

  always_comb begin
    head = '0;
    if (skid_vld)     head = skid_q;
    else if (ram_vld) head = ram_q;
  end

  assign axis_o_tvalid = skid_vld || ram_vld;
  assign axis_o_tlast  = head[DW];
  assign axis_o_tdata  = head[DW-1:0];

endmodule
